// File: rtl/spi_master_pkg.sv
// Shared types for the multi-select SPI master.
// Mode bundle, FSM state encoding and the four standard mode constants.
package spi_master_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP,
        RESP
    } state_t;

    localparam mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: one-cycle tick every CLK_DIV enabled cycles.
// Restarts from zero whenever cleared or disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_multi_master.sv
// SPI master sharing one SCLK/MOSI/MISO bus across NUM_CS selects.
// Per-request mode and length; request and response on valid/ready.
module spi_multi_master
    import spi_master_pkg::*;
#(
    parameter int NUM_CS  = 2,
    parameter int FRAME_W = 40,
    parameter int CLK_DIV = 2,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int LEN_W  = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CS_W-1:0]    req_cs,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [1:0]         req_mode,
    input  logic [FRAME_W-1:0] req_tx,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FRAME_W-1:0] rsp_data,
    output logic               rsp_err,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic [NUM_CS-1:0]  ss_n,
    output logic               busy
);

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len;
    logic                 r_cpha;
    logic [LEN_W:0]       r_edge;
    logic [FRAME_W-1:0]   r_tx;
    logic [FRAME_W-1:0]   r_rx;
    logic                 r_mosi;
    logic                 r_sclk;
    logic [NUM_CS-1:0]    r_ss_n;
    logic                 r_err;

    mode_t                w_mode;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_tick;
    logic                 w_step;
    logic [LEN_W:0]       w_edge_n;
    logic                 w_last;
    logic                 w_odd;

    assign w_mode    = mode_t'(req_mode);
    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_illegal = (req_len == '0)
                    || (32'(req_len) > FRAME_W)
                    || (32'(req_cs) >= NUM_CS);
    assign w_step    = w_tick && (r_state == SETUP || r_state == XFER);
    assign w_edge_n  = r_edge + 1'b1;
    assign w_last    = (w_edge_n == {r_len, 1'b0});
    assign w_odd     = w_edge_n[0];

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (r_state != IDLE && r_state != RESP),
        .i_clr  (w_next != r_state),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:        if (w_accept) w_next = w_illegal ? RESP : SETUP;
            SETUP, XFER: if (w_tick) w_next = w_last ? HOLD : XFER;
            HOLD:        if (w_tick) w_next = GAP;
            GAP:         if (w_tick) w_next = RESP;
            RESP:        if (rsp_ready) w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len  <= '0;
            r_cpha <= 1'b0;
            r_edge <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_mosi <= 1'b0;
            r_sclk <= 1'b0;
            r_ss_n <= '1;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_len  <= req_len;
            r_cpha <= w_mode.cpha;
            r_edge <= '0;
            r_rx   <= '0;
            r_err  <= w_illegal;
            if (!w_illegal) begin
                r_sclk <= w_mode.cpol;
                r_ss_n <= ~(NUM_CS'(1) << req_cs);
                // CPHA=0 presents the MSB before the first edge
                r_mosi <= w_mode.cpha ? 1'b0 : req_tx[FRAME_W-1];
                r_tx   <= w_mode.cpha ? req_tx : req_tx << 1;
            end
        end else if (w_step) begin
            r_edge <= w_edge_n;
            r_sclk <= ~r_sclk;
            if (w_odd != r_cpha) begin
                r_rx <= {r_rx[FRAME_W-2:0], miso};
            end
            if (w_odd == r_cpha && !w_last) begin
                r_mosi <= r_tx[FRAME_W-1];
                r_tx   <= r_tx << 1;
            end
        end else if (r_state == HOLD && w_tick) begin
            r_ss_n <= '1;
            r_mosi <= 1'b0;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rx;
    assign rsp_err   = r_err;
    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign ss_n      = r_ss_n;

endmodule

// File: tb/tb_spi_multi_master.sv
// Scoreboard bench for spi_multi_master with a behavioural SPI slave.
// Expected responses are queued at issue and checked at the rsp handshake.
module tb_spi_multi_master;
    import spi_master_pkg::*;

    localparam int NCS = 3;
    localparam int FW  = 40;
    localparam int D   = 2;

    typedef struct {
        int          cs;
        int          len;
        logic        cpha;
        logic        legal;
        logic [39:0] miso;
        logic [39:0] data;
        logic [39:0] mosi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cs;
    logic [5:0]  req_len;
    logic [1:0]  req_mode;
    logic [39:0] req_tx;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [39:0] rsp_data;
    logic        rsp_err;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [2:0]  ss_n;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    int          ncyc = 0;
    int          a_n = -100;
    int          mon_edges = 0;
    logic [39:0] mosi_cap;
    logic [2:0]  ss_seen;
    logic        multi;
    logic        prev_sclk;
    logic [2:0]  prev_ss;
    logic        prev_rv;
    exp_t        mon_e;

    always #5 clk = ~clk;

    spi_multi_master #(.NUM_CS(NCS), .FRAME_W(FW), .CLK_DIV(D)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cs(req_cs), .req_len(req_len), .req_mode(req_mode), .req_tx(req_tx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int cs, input int len, input logic [1:0] mode,
                                input logic [39:0] tx, input logic [39:0] mi);
        exp_t e;
        logic [63:0] mask;
        e.cs    = cs;
        e.len   = len;
        e.cpha  = mode[0];
        e.miso  = mi;
        e.legal = (len >= 1) && (len <= FW) && (cs < NCS);
        mask    = (64'd1 << len) - 64'd1;
        e.data  = e.legal ? (mi & mask[39:0]) : 40'd0;
        e.mosi  = e.legal ? 40'(tx >> (FW - len)) : 40'd0;
        return e;
    endfunction

    // Monitor + slave: counts SCLK edges, captures MOSI, drives MISO MSB first
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            mon_edges = 0;
            mosi_cap  = '0;
            ss_seen   = '0;
            multi     = 1'b0;
            miso      = 1'b0;
            a_n       = -100;
            prev_sclk = sclk;
            prev_ss   = ss_n;
            prev_rv   = rsp_valid;
        end else begin
            ncyc++;
            if (ncyc == a_n + 1) prev_sclk = sclk;
            if (sclk !== prev_sclk) begin
                mon_edges++;
                if (q.size() > 0 && (mon_edges[0] != q[0].cpha))
                    mosi_cap = {mosi_cap[38:0], mosi};
            end
            ss_seen = ss_seen | ~ss_n;
            if ($countones(~ss_n) > 1) multi = 1'b1;
            if (q.size() > 0 && prev_ss !== 3'b111 && ss_n === 3'b111)
                chk("ss_rise_time", 64'(ncyc - a_n - 1), 64'((2 * q[0].len + 1) * D));
            if (q.size() > 0 && rsp_valid && !prev_rv)
                chk("rsp_valid_time", 64'(ncyc - a_n - 1),
                    q[0].legal ? 64'((2 * q[0].len + 2) * D) : 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_err", rsp_err, !mon_e.legal);
                    chk("sclk_edges", 64'(mon_edges), mon_e.legal ? 64'(2 * mon_e.len) : 64'd0);
                    chk("ss_selected", ss_seen,
                        mon_e.legal ? 64'(1 << mon_e.cs) : 64'd0);
                    chk("ss_onehot", multi, 1'b0);
                    if (mon_e.legal) chk("mosi_bits", mosi_cap, mon_e.mosi);
                end
            end
            if (req_valid && req_ready) begin
                a_n       = ncyc;
                mon_edges = 0;
                mosi_cap  = '0;
                ss_seen   = '0;
                multi     = 1'b0;
            end
            miso = 1'b0;
            if (q.size() > 0 && q[0].legal) begin
                int samp;
                samp = q[0].cpha ? mon_edges / 2 : (mon_edges + 1) / 2;
                if (samp < q[0].len) miso = q[0].miso[q[0].len - 1 - samp];
            end
            prev_sclk = sclk;
            prev_ss   = ss_n;
            prev_rv   = rsp_valid;
        end
    end

    task automatic pulse_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic issue(input int cs, input int len, input logic [1:0] mode,
                         input logic [39:0] tx, input logic [39:0] mi);
        q.push_back(mk(cs, len, mode, tx, mi));
        req_cs    = 2'(cs);
        req_len   = 6'(len);
        req_mode  = mode;
        req_tx    = tx;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cs    = 2'($urandom);
        req_len   = 6'($urandom);
        req_mode  = 2'($urandom);
        req_tx    = {8'($urandom), 32'($urandom)};
    endtask

    task automatic do_req(input int cs, input int len, input logic [1:0] mode,
                          input logic [39:0] tx, input logic [39:0] mi, input bit hold);
        exp_t e;
        int k;
        e = mk(cs, len, mode, tx, mi);
        issue(cs, len, mode, tx, mi);
        k = 0;
        while (!rsp_valid && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            pulse_reset();
            return;
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                req_valid = i[0];
                chk("hold_valid", rsp_valid, 1'b1);
                chk("hold_data", rsp_data, e.data);
                chk("hold_req_ready", req_ready, 1'b0);
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
        end else begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (hold) chk("ready_after_rsp", req_ready, 1'b1);
    endtask

    initial begin
        int k;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_cs    = '0;
        req_len   = '0;
        req_mode  = '0;
        req_tx    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", ss_n, 3'b111);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 40'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        do_req(0, 8, MODE0, 40'hA5_0000_0000, 40'h3C, 1'b0);
        do_req(1, 40, MODE3, 40'h03_0012_3400, {32'($urandom), 8'h5A}, 1'b0);
        chk("mode3_sclk_idle", sclk, 1'b1);
        do_req(2, 16, MODE1, {8'($urandom), 32'($urandom)}, 40'h0FF0, 1'b0);
        do_req(2, 16, MODE0, {8'($urandom), 32'($urandom)}, 40'h0FF0, 1'b0);
        do_req(0, 0, MODE2, {8'($urandom), 32'($urandom)}, 40'hFF, 1'b0);
        do_req(NCS, 8, MODE0, {8'($urandom), 32'($urandom)}, 40'hFF, 1'b0);
        do_req(0, 41, MODE1, {8'($urandom), 32'($urandom)}, 40'hFF, 1'b0);
        do_req(1, 12, MODE2, {8'($urandom), 32'($urandom)}, 40'h0ABC, 1'b1);

        issue(0, 8, MODE1, {8'($urandom), 32'($urandom)}, 40'h77);
        k = 0;
        while (mon_edges < 7 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("midframe_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_ss_n", ss_n, 3'b111);
        chk("midrst_sclk", sclk, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_mosi", mosi, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        do_req(0, 8, MODE0, 40'hC3_0000_0000, 40'h96, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? 41 : (r == 2) ? 40 :
                  (r == 3) ? 1 : $urandom_range(1, 40);
            do_req($urandom_range(0, 3), len, 2'($urandom),
                   {8'($urandom), 32'($urandom)},
                   {8'($urandom), 32'($urandom)}, 1'b0);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
